// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants: inter-stage payload layouts, the NOP bubble
// and the occupancy encoding used by the skid-buffered stage register.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
    } id_ex_t;

    localparam int IF_ID_W = $bits(if_id_t);
    localparam int ID_EX_W = $bits(id_ex_t);

    // A bubble in IF/ID must decode as a NOP, so the instr field is not zero.
    localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc: 32'h0, pcplus4: 32'h0};

    // Occupancy of a skid-buffered stage, encoded as {skid_valid, main_valid}.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    function automatic logic [1:0] skid_state(input logic main_valid, input logic skid_valid);
        return {skid_valid, main_valid};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
// Synchronous active-low reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline-stage register with flush-to-bubble, optional skid slot
// and saturating stall/flush performance counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                   PAYLOAD_W  = IF_ID_W,
    parameter int                   SKID       = 1,
    parameter logic [PAYLOAD_W-1:0] BUBBLE_VAL = '0,
    parameter int                   CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_data,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    logic accept;
    logic emit;
    logic stall_inc;

    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;
    assign stall_inc = out_valid && !out_ready && !flush;

    generate
        if (SKID == 0) begin : g_single
            // in_ready sees out_ready combinationally: a beat can enter as the held one leaves.
            assign in_ready = rst && (!out_valid || out_ready);

            always_ff @(posedge clk) begin
                if (!rst || flush) begin
                    out_valid <= 1'b0;
                    out_data  <= BUBBLE_VAL;
                end else if (accept) begin
                    out_valid <= 1'b1;
                    out_data  <= in_data;
                end else if (emit) begin
                    out_valid <= 1'b0;
                    out_data  <= BUBBLE_VAL;
                end
            end
        end else begin : g_skid
            logic                 skid_valid;
            logic [PAYLOAD_W-1:0] skid_data;
            logic [1:0]           state;

            assign state = skid_state(out_valid, skid_valid);

            // Ready depends only on the skid flop, breaking the out_ready -> in_ready path.
            assign in_ready = rst && !skid_valid;

            always_ff @(posedge clk) begin
                if (!rst || flush) begin
                    out_valid  <= 1'b0;
                    out_data   <= BUBBLE_VAL;
                    skid_valid <= 1'b0;
                    skid_data  <= BUBBLE_VAL;
                end else begin
                    case (state)
                        ST_EMPTY: begin
                            if (accept) begin
                                out_valid <= 1'b1;
                                out_data  <= in_data;
                            end
                        end
                        ST_ONE: begin
                            if (emit && accept) begin
                                out_data <= in_data;
                            end else if (emit) begin
                                out_valid <= 1'b0;
                                out_data  <= BUBBLE_VAL;
                            end else if (accept) begin
                                skid_valid <= 1'b1;
                                skid_data  <= in_data;
                            end
                        end
                        ST_FULL: begin
                            if (emit) begin
                                out_data   <= skid_data;
                                skid_valid <= 1'b0;
                                skid_data  <= BUBBLE_VAL;
                            end
                        end
                        default: begin
                            // Skid-only occupancy is unreachable; fall back to empty.
                            out_valid  <= 1'b0;
                            out_data   <= BUBBLE_VAL;
                            skid_valid <= 1'b0;
                            skid_data  <= BUBBLE_VAL;
                        end
                    endcase
                end
            end
        end
    endgenerate

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .count (flush_cnt)
    );

endmodule
